// File: rtl/xuart_tx.sv
// xuart_tx: memory-mapped 8N1 UART transmitter fed by a small circular TX FIFO.
// Define XUART_PARITY_EN to add CTRL[0] and an even-parity bit after the data bits.
module xuart_tx #(
    parameter int DATA_W      = 32,
    parameter int FIFO_ADDR_W = 2,
    parameter int DIV_W       = 16,
    parameter int DIV_RST     = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              txd
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam logic [FIFO_ADDR_W:0] FULL_CNT = (FIFO_ADDR_W+1)'(DEPTH);

`ifdef XUART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]             mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_W:0]   count;
    logic                   overflow;
    logic [DIV_W-1:0]       div_q, div_lat, div_lat_n, cnt, cnt_n;
    logic [2:0]             bit_idx, bit_n;
    logic [7:0]             shift, shift_n;
    state_t                 state, state_n;
    logic                   txd_n;
    logic                   wr_en, push, push_ok, pop, full, empty, busy, bit_end;
    logic                   unused_hi;
`ifdef XUART_PARITY_EN
    logic                   ctrl_par, par_en, par_en_n, par_bit, par_bit_n;
`endif

    assign wr_en     = sel & we;
    assign push      = wr_en & (addr == 2'd0);
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign pop       = (state == IDLE) & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok   = push & (~full | pop);
    assign busy      = (state != IDLE);
    assign bit_end   = (cnt == '0);
    assign unused_hi = ^data_in[DATA_W-1:DIV_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data_in[7:0];
                wr_ptr      <= wr_ptr + FIFO_ADDR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_ADDR_W+1)'(1);
                2'b01:   count <= count - (FIFO_ADDR_W+1)'(1);
                default: ;
            endcase
            if (push && !push_ok)
                overflow <= 1'b1;
            else if (wr_en && addr == 2'd1 && data_in[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_W'(DIV_RST);
`ifdef XUART_PARITY_EN
            ctrl_par <= 1'b0;
`endif
        end else if (wr_en) begin
            if (addr == 2'd2)
                div_q <= (data_in[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : data_in[DIV_W-1:0];
`ifdef XUART_PARITY_EN
            if (addr == 2'd3)
                ctrl_par <= data_in[0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            div_lat <= DIV_W'(DIV_RST);
            txd     <= 1'b1;
`ifdef XUART_PARITY_EN
            par_en  <= 1'b0;
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            div_lat <= div_lat_n;
            txd     <= txd_n;
`ifdef XUART_PARITY_EN
            par_en  <= par_en_n;
            par_bit <= par_bit_n;
`endif
        end
    end

    // Divisor and parity enable are snapshotted at the pop so mid-frame
    // register writes only take effect on the following frame.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        shift_n   = shift;
        div_lat_n = div_lat;
`ifdef XUART_PARITY_EN
        par_en_n  = par_en;
        par_bit_n = par_bit;
`endif
        case (state)
            IDLE: begin
                if (pop) begin
                    state_n   = START;
                    shift_n   = mem[rd_ptr];
                    div_lat_n = div_q;
                    cnt_n     = div_q - DIV_W'(1);
`ifdef XUART_PARITY_EN
                    par_en_n  = ctrl_par;
                    par_bit_n = ^mem[rd_ptr];
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                    cnt_n   = div_lat - DIV_W'(1);
                end else begin
                    cnt_n = cnt - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = {1'b0, shift[7:1]};
                    bit_n   = bit_idx + 3'd1;
                    cnt_n   = div_lat - DIV_W'(1);
                    if (bit_idx == 3'd7) begin
`ifdef XUART_PARITY_EN
                        state_n = par_en ? PARITY : STOP;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt - DIV_W'(1);
                end
            end
`ifdef XUART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    cnt_n   = div_lat - DIV_W'(1);
                end else begin
                    cnt_n = cnt - DIV_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end)
                    state_n = IDLE;
                else
                    cnt_n = cnt - DIV_W'(1);
            end
            default: state_n = IDLE;
        endcase

        // txd is registered from the next state so the line never glitches.
        txd_n = 1'b1;
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
`ifdef XUART_PARITY_EN
            PARITY:  txd_n = par_bit_n;
`endif
            default: txd_n = 1'b1;
        endcase
    end

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                2'd1: begin
                    data_out[0]                 = busy;
                    data_out[1]                 = full;
                    data_out[2]                 = empty;
                    data_out[3]                 = overflow;
                    data_out[4 +: FIFO_ADDR_W+1] = count;
                end
                2'd2: data_out[DIV_W-1:0] = div_q;
`ifdef XUART_PARITY_EN
                2'd3: data_out[0] = ctrl_par;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xuart_tx.sv
// Scoreboard bench for xuart_tx: register reads and serial frames are queued as
// expectations and checked by independent monitors.
`timescale 1ns/1ps
module tb_xuart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        txd;

    xuart_tx #(.DATA_W(32), .FIFO_ADDR_W(2), .DIV_W(16), .DIV_RST(868)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .txd(txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         par;
    } frm_t;

    frm_t        frm_q[$];
    logic [31:0] rd_q[$];
    string       rd_nm[$];
    int          starts[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          mon_busy = 1'b0;
    bit          abort = 1'b0;
    bit          rd_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Register read monitor.
    always @(negedge clk) begin
        if (rd_chk && rd_q.size() != 0)
            check(rd_nm.pop_front(), data_out, rd_q.pop_front());
    end

    // Frame monitor: every cycle of every bit period must match the expected level.
    frm_t        mf;
    logic [10:0] ebits;
    int          nb;
    logic        got;
    logic        prev_txd = 1'b1;

    always begin
        @(negedge clk);
        if (!rst && txd === 1'b0 && prev_txd === 1'b1) begin
            if (frm_q.size() == 0) begin
                check("frame_unexpected_start", 32'(txd), 32'd1);
            end else begin
                mf = frm_q.pop_front();
                mon_busy = 1'b1;
                starts.push_back(cyc);
                nb = mf.par ? 11 : 10;
                ebits = '1;
                ebits[0] = 1'b0;
                for (int i = 0; i < 8; i++) ebits[1+i] = mf.data[i];
                if (mf.par) ebits[9] = ^mf.data;
                for (int k = 0; k < nb && !abort; k++) begin
                    got = ebits[k];
                    for (int j = 0; j < mf.div && !abort; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (txd !== ebits[k]) got = txd;
                    end
                    if (!abort)
                        check($sformatf("frame_%02h_bit%0d", mf.data, k), 32'(got), 32'(ebits[k]));
                end
                mon_busy = 1'b0;
            end
        end
        prev_txd = txd;
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0; data_in = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        @(posedge clk); #1;
        rd_q.push_back(e);
        rd_nm.push_back(nm);
        sel = 1'b1; we = 1'b0; addr = a; rd_chk = 1'b1;
        @(posedge clk); #1;
        sel = 1'b0; rd_chk = 1'b0;
    endtask

    task automatic tx_byte(input logic [7:0] b, input int dv, input bit p, input bit acc);
        frm_t f;
        f.data = b; f.div = dv; f.par = p;
        if (acc) frm_q.push_back(f);
        wr(2'd0, {24'd0, b});
    endtask

    task automatic drain(input int max, input string nm);
        int n = 0;
        while ((frm_q.size() != 0 || mon_busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(nm, frm_q.size() + int'(mon_busy), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    int s0;
    int n;
    int bc;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; addr = 2'd2;
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("dout_nosel", data_out, 32'd0);
        rd(2'd1, 32'h4, "rst_status");
        rd(2'd2, 32'd868, "rst_div");
        rd(2'd3, 32'd0, "rst_ctrl");
        rd(2'd0, 32'd0, "txdata_reads0");

        // Single byte 0xA5 at DIV=4; busy must stay high for 40 cycles.
        wr(2'd2, 32'd4);
        tx_byte(8'hA5, 4, 1'b0, 1'b1);
        sel = 1'b1; we = 1'b0; addr = 2'd1;
        n = 0;
        while (!data_out[0] && n < 20) begin @(negedge clk); n++; end
        bc = 0;
        while (data_out[0] && bc < 200) begin bc++; @(negedge clk); end
        sel = 1'b0;
        check("busy_len", bc, 40);
        drain(200, "drain_single");

        // Overflow: first byte pops, four fill the FIFO, the sixth is dropped.
        wr(2'd2, 32'd100);
        tx_byte(8'h11, 100, 1'b0, 1'b1);
        tx_byte(8'h22, 100, 1'b0, 1'b1);
        tx_byte(8'h33, 100, 1'b0, 1'b1);
        tx_byte(8'h44, 100, 1'b0, 1'b1);
        tx_byte(8'h55, 100, 1'b0, 1'b1);
        tx_byte(8'h66, 100, 1'b0, 1'b0);
        rd(2'd1, 32'h4B, "ovf_status");
        wr(2'd1, 32'h8);
        rd(2'd1, 32'h43, "ovf_cleared");
        drain(6000, "drain_ovf");
        rd(2'd1, 32'h4, "ovf_idle_status");

        // Back-to-back frames at DIV=2: starts 21 cycles apart.
        wr(2'd2, 32'd2);
        s0 = starts.size();
        tx_byte(8'h00, 2, 1'b0, 1'b1);
        tx_byte(8'hFF, 2, 1'b0, 1'b1);
        drain(200, "drain_b2b");
        check("b2b_spacing", starts[s0+1] - starts[s0], 21);

        // Divisor floor and mid-frame divisor change.
        wr(2'd2, 32'd1);
        rd(2'd2, 32'd2, "div_min1");
        wr(2'd2, 32'd0);
        rd(2'd2, 32'd2, "div_min0");
        s0 = starts.size();
        tx_byte(8'h3C, 2, 1'b0, 1'b1);
        tx_byte(8'hC3, 8, 1'b0, 1'b1);
        wr(2'd2, 32'd8);
        rd(2'd2, 32'd8, "div_new");
        drain(400, "drain_divchg");
        check("divchg_spacing", starts[s0+1] - starts[s0], 21);

`ifdef XUART_PARITY_EN
        wr(2'd3, 32'd1);
        rd(2'd3, 32'd1, "ctrl_par_rd");
        wr(2'd2, 32'd2);
        s0 = starts.size();
        tx_byte(8'h07, 2, 1'b1, 1'b1);
        tx_byte(8'h00, 2, 1'b1, 1'b1);
        drain(300, "drain_par");
        check("par_spacing", starts[s0+1] - starts[s0], 23);
        wr(2'd3, 32'd0);
        rd(2'd3, 32'd0, "ctrl_par_off");
`else
        wr(2'd3, 32'd1);
        rd(2'd3, 32'd0, "ctrl_ignored");
`endif

        // Reset in the middle of a frame.
        wr(2'd2, 32'd4);
        tx_byte(8'h5A, 4, 1'b0, 1'b1);
        tx_byte(8'hE7, 4, 1'b0, 1'b1);
        repeat (12) @(posedge clk);
        #1 abort = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_txd", 32'(txd), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        frm_q.delete();
        n = 0;
        while (mon_busy && n < 100) begin @(negedge clk); n++; end
        abort = 1'b0;
        s0 = starts.size();
        rd(2'd1, 32'h4, "midrst_status");
        rd(2'd2, 32'd868, "midrst_div");
        repeat (60) @(negedge clk);
        check("midrst_quiet", starts.size(), s0);
        check("midrst_txd_idle", 32'(txd), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/xuart_tx.md
Name: xuart_tx

Overview:
Memory-mapped UART transmitter. It sits directly downstream of the picoVersat address decoder and is driven by one of the decoder's per-peripheral select lines. Its read data feeds the decoder's read-data mux. CPU writes push bytes into a small TX FIFO; a bit-serial FSM drives an 8N1 frame on txd, and status can be polled through a register.

Parameters:
DATA_W, 32, width of the CPU data bus
FIFO_ADDR_W, 2, log2 of TX FIFO depth (default depth 4)
DIV_W, 16, width of the baud divisor register
DIV_RST, 868, divisor value after reset (100 MHz / 115200)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sel  input  1  block select from the address decoder
we  input  1  write enable, qualified by sel
addr  input  2  register offset
data_in  input  DATA_W  write data
data_out  output  DATA_W  read data, combinational from addr
txd  output  1  serial output, idle high

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high: all state is cleared on the rising clk edge where rst=1.
- Register map (write = sel & we):
  - addr 0 TXDATA: write pushes data_in[7:0] into the FIFO; reads 0.
  - addr 1 STATUS: read bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[4+FIFO_ADDR_W:4] FIFO count; other bits 0. Writing with data_in[3]=1 clears overflow.
  - addr 2 DIV: read/write divisor; a written value <2 is stored as 2.
  - addr 3 CTRL: see Optional Feature.
- data_out is zero-latency: it is valid in the same cycle as sel/addr. When sel=0, data_out is 0.
- Reset values: txd=1, FSM=IDLE, FIFO empty (count=0), overflow=0, DIV=DIV_RST, data_out=0.
- FIFO:
  - Circular buffer with wrap-around read and write pointers and a count of width FIFO_ADDR_W+1.
  - A push is accepted if count < depth, or if a pop happens in the same cycle.
  - When a push is rejected, the byte is dropped and overflow is set.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is not empty: pop into shift register, latch DIV into the bit-period counter, go to START on the next edge.
  - START: txd=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for DIV cycles, then shift right. After bit 7, go to STOP.
  - STOP: txd=1 for DIV cycles, then go to IDLE. Back-to-back frames: IDLE lasts exactly 1 cycle when the FIFO is non-empty.
- Bit-period counter counts DIV-1 down to 0. The state or bit advances on 0.
- DIV is latched at frame start. A DIV write mid-frame affects the next frame only.
- Frame length = 10*DIV + 1 cycles, including the IDLE pop cycle.
- Reset mid-frame: txd returns to 1 on that edge, FIFO contents are discarded, and DIV returns to DIV_RST.
- busy goes high on the cycle after the pop and falls on the STOP-to-IDLE transition.

Optional Feature:
Macro XUART_PARITY_EN.
- Defined:
  - CTRL bit0 = parity enable, reset 0, read/write.
  - When parity is enabled, a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for DIV cycles.
  - The frame becomes 11*DIV + 1 cycles.
  - The parity-enable bit is latched at frame start.
- Undefined: CTRL reads 0, writes to CTRL are ignored, and the PARITY state is absent.

Test Plan:
- Reset: assert rst for 2 cycles -> txd=1; STATUS read = 0x4 (empty only); DIV read = 868.
- Single byte: DIV=4, write 0xA5 to TXDATA.
  - txd: start 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop 1 for 4 cycles.
  - busy is high for 40 cycles.
- FIFO full/overflow: DIV=100, write 6 bytes quickly.
  - First byte popped, next 4 fill the FIFO, 6th dropped.
  - STATUS shows full=1, overflow=1, count=4.
  - Write 0x8 to STATUS -> overflow=0.
- Back-to-back frames: DIV=2, push 0x00, 0xFF.
  - Second start bit begins exactly 1 cycle after the first stop bit ends; total span 42 cycles.
- DIV boundary and mid-frame change:
  - Write DIV=1 -> reads 2.
  - Write DIV=8 during a frame running at DIV=2 -> current frame keeps 2-cycle bits; next frame uses 8.
- Parity, only with XUART_PARITY_EN: CTRL=1, DIV=2, send 0x07 -> parity bit=1 after data bits; frame is 23 cycles.
